instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: word-addressed PC, loader-writable instruction memory,
// and the IF/ID pipeline register with redirect, stall and HALT freeze handling.
module instruction_fetch #(
  parameter int NB_PC        = 32,
  parameter int NB_INSTR     = 32,
  parameter int IMEM_DEPTH   = 1024,
  parameter int NB_IMEM_ADDR = $clog2(IMEM_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pipe_enabled,
  input  logic                    i_stall,
  input  logic                    i_branch_taken,
  input  logic [NB_PC-1:0]        i_branch_pc,
  input  logic                    i_jump_taken,
  input  logic [NB_PC-1:0]        i_jump_pc,
  input  logic                    i_imem_wr_en,
  input  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr,
  input  logic [NB_INSTR-1:0]     i_imem_wr_data,
  output logic [NB_INSTR-1:0]     o_instr,
  output logic [NB_PC-1:0]        o_pc_plus4,
  output logic                    o_valid,
  output logic                    o_halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                r_state;
  logic [NB_PC-1:0]      r_pc;
  logic [NB_INSTR-1:0]   r_mem [IMEM_DEPTH];

  logic [NB_INSTR-1:0]   w_fetch;
  logic [NB_PC-1:0]      w_pc_inc;
  logic                  w_redirect;
  logic [NB_PC-1:0]      w_target;
  logic                  w_is_halt;

  // PCs beyond the memory size simply wrap onto it through the low index bits.
  assign w_fetch    = r_mem[r_pc[NB_IMEM_ADDR-1:0]];
  assign w_pc_inc   = r_pc + 1'b1;
  assign w_redirect = i_jump_taken | i_branch_taken;
  assign w_target   = i_jump_taken ? i_jump_pc : i_branch_pc;
  assign w_is_halt  = (w_fetch[31:26] == 6'h3F);
  assign o_halted   = (r_state == HALTED);

  always_ff @(posedge i_clk) begin
    if (i_imem_wr_en) begin
      r_mem[i_imem_wr_addr] <= i_imem_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= '0;
      o_instr    <= '0;
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
      r_state    <= RUN;
    end else if (i_pipe_enabled) begin
      if (w_redirect) begin
        r_pc       <= w_target;
        o_instr    <= '0;
        o_pc_plus4 <= '0;
        o_valid    <= 1'b0;
        r_state    <= RUN;
      end else if (i_stall) begin
        r_pc       <= r_pc;
      end else if (r_state == HALTED) begin
        o_instr    <= '0;
        o_pc_plus4 <= '0;
        o_valid    <= 1'b0;
      end else begin
        // The HALT word itself is delivered; the PC then stays frozen just past it.
        o_instr    <= w_fetch;
        o_pc_plus4 <= w_pc_inc;
        o_valid    <= 1'b1;
        r_pc       <= w_pc_inc;
        if (w_is_halt) begin
          r_state  <= HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

  localparam int NB_PC        = 32;
  localparam int NB_INSTR     = 32;
  localparam int IMEM_DEPTH   = 1024;
  localparam int NB_IMEM_ADDR = 10;

  localparam logic [31:0] WORD_A = 32'hAAAA0001;
  localparam logic [31:0] WORD_B = 32'hBBBB0002;
  localparam logic [31:0] WORD_C = 32'hCCCC0003;
  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic                    i_clk;
  logic                    i_rst;
  logic                    i_pipe_enabled;
  logic                    i_stall;
  logic                    i_branch_taken;
  logic [NB_PC-1:0]        i_branch_pc;
  logic                    i_jump_taken;
  logic [NB_PC-1:0]        i_jump_pc;
  logic                    i_imem_wr_en;
  logic [NB_IMEM_ADDR-1:0] i_imem_wr_addr;
  logic [NB_INSTR-1:0]     i_imem_wr_data;
  logic [NB_INSTR-1:0]     o_instr;
  logic [NB_PC-1:0]        o_pc_plus4;
  logic                    o_valid;
  logic                    o_halted;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 0;

  instruction_fetch #(
    .NB_PC(NB_PC), .NB_INSTR(NB_INSTR), .IMEM_DEPTH(IMEM_DEPTH), .NB_IMEM_ADDR(NB_IMEM_ADDR)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pipe_enabled(i_pipe_enabled), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_pc(i_branch_pc),
    .i_jump_taken(i_jump_taken), .i_jump_pc(i_jump_pc),
    .i_imem_wr_en(i_imem_wr_en), .i_imem_wr_addr(i_imem_wr_addr), .i_imem_wr_data(i_imem_wr_data),
    .o_instr(o_instr), .o_pc_plus4(o_pc_plus4), .o_valid(o_valid), .o_halted(o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: program memory image, fetch address and the IF/ID contents.
  logic [31:0] modelMem [IMEM_DEPTH];
  logic [31:0] modelPc    = '0;
  logic [31:0] modelInstr = '0;
  logic [31:0] modelPp    = '0;
  bit          modelValid = 0;
  bit          modelHalt  = 0;

  always @(posedge i_clk) begin
    logic [31:0] word;
    if (i_rst) begin
      modelPc = '0; modelInstr = '0; modelPp = '0; modelValid = 0; modelHalt = 0;
    end else if (i_pipe_enabled) begin
      if (i_jump_taken || i_branch_taken) begin
        modelPc    = i_jump_taken ? i_jump_pc : i_branch_pc;
        modelInstr = '0; modelPp = '0; modelValid = 0; modelHalt = 0;
      end else if (i_stall) begin
        modelPc = modelPc;
      end else if (modelHalt) begin
        modelInstr = '0; modelPp = '0; modelValid = 0;
      end else begin
        word       = modelMem[modelPc % IMEM_DEPTH];
        modelInstr = word;
        modelPp    = modelPc + 1;
        modelValid = 1;
        modelPc    = modelPc + 1;
        if (word[31:26] == 6'h3F) modelHalt = 1;
      end
    end
    if (i_imem_wr_en) modelMem[i_imem_wr_addr] = i_imem_wr_data;
  end

  always @(negedge i_clk) begin
    if (checkEn) begin
      testsRun++;
      if (o_instr !== modelInstr || o_pc_plus4 !== modelPp ||
          o_valid !== modelValid || o_halted !== modelHalt) begin
        testsFailed++;
        $display("[TB] FAIL model @%0t: got instr=%h pp=%h valid=%b halted=%b, want instr=%h pp=%h valid=%b halted=%b",
                 $time, o_instr, o_pc_plus4, o_valid, o_halted, modelInstr, modelPp, modelValid, modelHalt);
      end
    end
  end

  // One clock edge with the given control inputs; returns on the following falling edge.
  task automatic applyStimulus(input bit pipe, input bit stall, input bit br,
                               input logic [31:0] bpc, input bit jmp, input logic [31:0] jpc);
    i_pipe_enabled = pipe;
    i_stall        = stall;
    i_branch_taken = br;
    i_branch_pc    = bpc;
    i_jump_taken   = jmp;
    i_jump_pc      = jpc;
    @(negedge i_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expInstr,
                             input logic [31:0] expPp, input bit expValid, input bit expHalt);
    testsRun++;
    if (o_instr !== expInstr || o_pc_plus4 !== expPp || o_valid !== expValid || o_halted !== expHalt) begin
      testsFailed++;
      $display("[TB] FAIL %s: got instr=%h pp=%h valid=%b halted=%b, want instr=%h pp=%h valid=%b halted=%b",
               name, o_instr, o_pc_plus4, o_valid, o_halted, expInstr, expPp, expValid, expHalt);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_pipe_enabled = 0; i_stall = 0; i_branch_taken = 0; i_branch_pc = '0;
    i_jump_taken = 0; i_jump_pc = '0; i_imem_wr_en = 0; i_imem_wr_addr = '0; i_imem_wr_data = '0;
    @(negedge i_clk);
    checkEn = 1;
    checkOutput("reset", 32'h0, 32'h0, 0, 0);

    // Fill memory while held in reset with the pipe disabled; A,B,C at 0..2.
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      i_imem_wr_en   = 1'b1;
      i_imem_wr_addr = NB_IMEM_ADDR'(i);
      i_imem_wr_data = (i == 0) ? WORD_A : (i == 1) ? WORD_B : (i == 2) ? WORD_C : (32'h10000000 | 32'(i));
      @(negedge i_clk);
    end
    i_imem_wr_en = 1'b0;
    i_rst        = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("fetch A", WORD_A, 32'h1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("fetch B", WORD_B, 32'h2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 0, 0, 0); checkOutput("stall hold B", WORD_B, 32'h2, 1, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("fetch C", WORD_C, 32'h3, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("fetch 3", 32'h10000003, 32'h4, 1, 0);

    applyStimulus(1, 0, 1, 32'h40, 0, 0); checkOutput("branch flush", 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("branch target", 32'h10000040, 32'h41, 1, 0);

    applyStimulus(1, 0, 1, 32'h20, 1, 32'h10); checkOutput("jump+branch flush", 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);           checkOutput("jump priority", 32'h10000010, 32'h11, 1, 0);

    applyStimulus(1, 1, 1, 32'h80, 0, 0); checkOutput("redirect in stall", 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("after stall redirect", 32'h10000080, 32'h81, 1, 0);

    // Write the word being fetched this very edge: the old word must come out.
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 10'h81; i_imem_wr_data = 32'h12345678;
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("write-read old", 32'h10000081, 32'h82, 1, 0);
    i_imem_wr_en = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 32'h81);
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("written word", 32'h12345678, 32'h82, 1, 0);

    // Pipe disabled: redirect ignored, memory still writable.
    i_imem_wr_en = 1'b1; i_imem_wr_addr = 10'd5; i_imem_wr_data = HALT_W;
    applyStimulus(0, 0, 1, 32'h200, 0, 0); checkOutput("pipe off hold", 32'h12345678, 32'h82, 1, 0);
    i_imem_wr_en = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);       checkOutput("pipe off hold 2", 32'h12345678, 32'h82, 1, 0);

    applyStimulus(1, 0, 0, 0, 1, 32'h3);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("fetch 4", 32'h10000004, 32'h5, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("HALT capture", HALT_W, 32'h6, 1, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0); checkOutput("halted bubble", 32'h0, 32'h0, 0, 1);
    end
    applyStimulus(1, 0, 0, 0, 1, 32'h0); checkOutput("unhalt jump", 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);     checkOutput("resume at 0", WORD_A, 32'h1, 1, 0);

    applyStimulus(1, 0, 0, 0, 1, 32'h3FF);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("last word", 32'h100003FF, 32'h400, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);  checkOutput("wrap to mem0", WORD_A, 32'h401, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    i_rst = 1'b1;
    applyStimulus(0, 0, 1, 32'h55, 0, 0); checkOutput("mid-run reset", 32'h0, 32'h0, 0, 0);
    i_rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("restart at 0", WORD_A, 32'h1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);      checkOutput("restart B", WORD_B, 32'h2, 1, 0);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
